rom_load_ctrl: RTL and testbench
================================

Name: rom_load_ctrl

Overview:
- Sequences loading of game ROM images from the MiSTer ioctl download stream into the banked rom instances.
- Decodes each download byte into an address, data and a one-hot load strobe for the target region. Each strobe drives one rom's iaddr/idata/iload.
- Holds the game core in reset until the load completes plus a settle delay.
- Sits between hps_io and the rom array in the core top level.

Parameters:
- ADDR_W, 16, address width of each rom region (region size 2^ADDR_W bytes).
- REG_BITS, 2, region-select bits taken above ADDR_W; N_REG = 2^REG_BITS regions.
- ROM_INDEX, 0, ioctl_index value that identifies a ROM download; other indices are ignored.
- SETTLE_CYC, 16, clock cycles after download end before the core is released (range 1..255).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  high while hps_io is streaming a file.
- ioctl_index  in  8  file index of the current download.
- ioctl_wr  in  1  one-cycle byte-valid strobe.
- ioctl_addr  in  25  byte address within the file.
- ioctl_dout  in  8  download byte.
- rom_iaddr  out  ADDR_W  region-local write address, shared by all regions.
- rom_idata  out  8  write data, shared by all regions.
- rom_iload  out  N_REG  one-hot load strobe; bit k drives region k iload.
- cpu_reset  out  1  high = hold game core in reset.
- rom_ready  out  1  high = a complete ROM set has been loaded.
- load_err  out  1  sticky flag: a byte addressed beyond the last region.
- byte_count  out  25  bytes accepted in the current or last load.

Behaviour:
- Reset values: rom_iload=0, rom_iaddr=0, rom_idata=0, cpu_reset=1, rom_ready=0, load_err=0, byte_count=0. State = IDLE.
- active = ioctl_download && (ioctl_index == ROM_INDEX).
- States and transitions:
  - IDLE: cpu_reset=1, rom_ready=0. Goes to LOAD when active.
  - LOAD: cpu_reset=1, rom_ready=0.
    - On entry: byte_count cleared to 0 and load_err cleared.
    - Each ioctl_wr in LOAD accepts one byte.
    - Goes to SETTLE when active falls.
  - SETTLE: a cycle counter is loaded with SETTLE_CYC on entry and decrements each cycle. Goes to DONE on the cycle the counter reaches 0, so cpu_reset falls exactly SETTLE_CYC+1 cycles after active falls. If active rises again, go to LOAD.
  - DONE: cpu_reset=0 and rom_ready=1. If active rises, go to LOAD; cpu_reset=1 and rom_ready=0 on the next cycle.
- Byte accept: on an ioctl_wr cycle in LOAD (including the entry cycle if ioctl_wr is coincident with active rising):
  - Register rom_iaddr = ioctl_addr[ADDR_W-1:0] and rom_idata = ioctl_dout.
  - sel = ioctl_addr[ADDR_W+REG_BITS-1:ADDR_W]; set rom_iload[sel]=1 for exactly one cycle.
  - Latency: the strobe appears 1 cycle after ioctl_wr.
  - byte_count increments by 1 and wraps at 2^25.
- Overflow: if any ioctl_addr bit above ADDR_W+REG_BITS-1 is set, no rom_iload bit asserts, load_err is set (sticky until the next LOAD entry), and byte_count still increments.
- Foreign index: ioctl_wr with a non-matching index, or ioctl_wr outside LOAD, produces no strobe and no count. State is unchanged, except that a matching-index download rising enters LOAD.
- Back-to-back ioctl_wr on consecutive cycles must each produce a strobe; there is no stall.
- Outputs rom_iaddr and rom_idata hold their last value when there is no strobe.
- Reset mid-load: returns to IDLE next cycle; rom_iload=0, cpu_reset=1, rom_ready=0. A partially loaded image is not flagged ready.

Test Plan:
- Reset, then index 0 download of 4 bytes at addr 0x00000..0x00003, data AA,BB,CC,DD, one per cycle -> rom_iload=0001 for 4 consecutive cycles, each 1 cycle after its ioctl_wr; rom_iaddr 0..3 with matching data; byte_count=4.
- Byte at ioctl_addr=0x2_1234 (ADDR_W=16) -> rom_iload=0100, rom_iaddr=0x1234; byte at 0x4_0000 -> no strobe, load_err=1, byte_count incremented.
- Download ends with SETTLE_CYC=16 -> cpu_reset stays 1 for 17 cycles after ioctl_download falls, then cpu_reset=0 and rom_ready=1.
- ioctl_index=1 download of 10 bytes in DONE -> no strobes, rom_ready stays 1, byte_count unchanged.
- Second index 0 download starting from DONE -> cpu_reset=1 and rom_ready=0 next cycle; byte_count and load_err cleared.
- Reset asserted after 3 of 8 bytes -> next cycle rom_iload=0, cpu_reset=1, rom_ready=0. Later ioctl_wr with no new download rising -> no strobes.

Source files
------------

// File: rtl/rom_load_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : rom_load_ctrl_if
//  Brief    : ioctl download stream in, banked-rom write bus out.
//  Revision : 1.0  initial release
// ============================================================================
interface rom_load_ctrl_if #(
    parameter int ADDR_W   = 16,
    parameter int REG_BITS = 2
);
    localparam int N_REG = 1 << REG_BITS;

    logic                ioctl_download;
    logic [7:0]          ioctl_index;
    logic                ioctl_wr;
    logic [24:0]         ioctl_addr;
    logic [7:0]          ioctl_dout;
    logic [ADDR_W-1:0]   rom_iaddr;
    logic [7:0]          rom_idata;
    logic [N_REG-1:0]    rom_iload;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  rom_iaddr, rom_idata, rom_iload
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output rom_iaddr, rom_idata, rom_iload
    );
endinterface
`default_nettype wire

// File: rtl/rom_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rom_load_ctrl
//  Brief    : Steers ioctl ROM download bytes into banked roms, holds the
//             game core in reset until the load has settled.
//  Revision : 1.0  initial release
// ============================================================================
module rom_load_ctrl #(
    parameter int          ADDR_W     = 16,
    parameter int          REG_BITS   = 2,
    parameter logic [7:0]  ROM_INDEX  = 8'd0,
    parameter int          SETTLE_CYC = 16
) (
    input  wire logic      clk,
    input  wire logic      reset,
    rom_load_ctrl_if.slave bus,
    output logic           cpu_reset,
    output logic           rom_ready,
    output logic           load_err,
    output logic [24:0]    byte_count
);
    localparam int         N_REG        = 1 << REG_BITS;
    localparam int         c_top        = ADDR_W + REG_BITS;
    localparam logic [7:0] c_settle_ini = 8'(SETTLE_CYC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic [7:0]          r_cnt;
    logic [N_REG-1:0]    r_iload;
    logic [ADDR_W-1:0]   r_iaddr;
    logic [7:0]          r_idata;
    logic                r_cpu_reset;
    logic                r_rom_ready;
    logic                r_load_err;
    logic [24:0]         r_byte_count;

    logic                w_active;
    logic                w_entry;
    logic                w_accept;
    logic                w_ovf;
    logic [REG_BITS-1:0] w_sel;
    logic [N_REG-1:0]    w_onehot;

    // A matching download is live only in LOAD or on the cycle entering it,
    // so a byte is accepted whenever a write arrives while active.
    assign w_active = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
    assign w_entry  = w_active && (r_state != S_LOAD);
    assign w_accept = w_active && bus.ioctl_wr;
    assign w_sel    = bus.ioctl_addr[c_top-1:ADDR_W];
    assign w_onehot = N_REG'(1) << w_sel;

    generate
        if (c_top < 25) begin : g_ovf
            assign w_ovf = |bus.ioctl_addr[24:c_top];
        end else begin : g_no_ovf
            assign w_ovf = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_iload      <= '0;
            r_iaddr      <= '0;
            r_idata      <= 8'd0;
            r_cpu_reset  <= 1'b1;
            r_rom_ready  <= 1'b0;
            r_load_err   <= 1'b0;
            r_byte_count <= 25'd0;
        end else begin
            r_iload <= '0;
            if (w_accept && !w_ovf) begin
                r_iload <= w_onehot;
                r_iaddr <= bus.ioctl_addr[ADDR_W-1:0];
                r_idata <= bus.ioctl_dout;
            end

            if (w_entry) begin
                r_byte_count <= w_accept ? 25'd1 : 25'd0;
                r_load_err   <= w_accept && w_ovf;
            end else if (w_accept) begin
                r_byte_count <= r_byte_count + 25'd1;
                if (w_ovf) begin
                    r_load_err <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_active) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!w_active) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= c_settle_ini;
                    end
                end
                S_SETTLE: begin
                    if (w_active) begin
                        r_state <= S_LOAD;
                    end else if (r_cnt == 8'd0) begin
                        r_state     <= S_DONE;
                        r_cpu_reset <= 1'b0;
                        r_rom_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    if (w_active) begin
                        r_state     <= S_LOAD;
                        r_cpu_reset <= 1'b1;
                        r_rom_ready <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rom_iload = r_iload;
    assign bus.rom_iaddr = r_iaddr;
    assign bus.rom_idata = r_idata;
    assign cpu_reset     = r_cpu_reset;
    assign rom_ready     = r_rom_ready;
    assign load_err      = r_load_err;
    assign byte_count    = r_byte_count;
endmodule
`default_nettype wire

// File: tb/tb_rom_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_load_ctrl
//  Brief    : Directed stimulus with a strobe scoreboard for rom_load_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rom_load_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_reset;
    logic        rom_ready;
    logic        load_err;
    logic [24:0] byte_count;

    always #5 clk = ~clk;

    rom_load_ctrl_if #(.ADDR_W(16), .REG_BITS(2)) bus ();

    rom_load_ctrl #(
        .ADDR_W     (16),
        .REG_BITS   (2),
        .ROM_INDEX  (8'd0),
        .SETTLE_CYC (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .cpu_reset  (cpu_reset),
        .rom_ready  (rom_ready),
        .load_err   (load_err),
        .byte_count (byte_count)
    );

    typedef struct {
        logic [3:0]  load;
        logic [15:0] addr;
        logic [7:0]  data;
        int          at;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: every nonzero rom_iload must match the head entry,
    // and a head entry whose cycle has passed without a strobe is missing.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].at < cyc) begin
                total++;
                bad++;
                $display("FAIL strobe_missing: got none at cycle %0d, expected load=%b addr=%h data=%h",
                         q[0].at, q[0].load, q[0].addr, q[0].data);
                void'(q.pop_front());
            end
            if (bus.rom_iload != 4'b0000) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL strobe_unexpected: got load=%b addr=%h at cycle %0d, expected no strobe",
                             bus.rom_iload, bus.rom_iaddr, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (bus.rom_iload !== e.load || bus.rom_iaddr !== e.addr ||
                        bus.rom_idata !== e.data || cyc != e.at) begin
                        bad++;
                        $display("FAIL strobe_value: got load=%b addr=%h data=%h cyc=%0d, expected load=%b addr=%h data=%h cyc=%0d",
                                 bus.rom_iload, bus.rom_iaddr, bus.rom_idata, cyc,
                                 e.load, e.addr, e.data, e.at);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d,
                        input logic [3:0] exp_load, input logic [15:0] exp_addr);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        if (exp_load != 4'b0000) begin
            q.push_back('{exp_load, exp_addr, d, cyc + 1});
        end
        tick();
        bus.ioctl_wr = 1'b0;
    endtask

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'd0;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_iload", 32'(bus.rom_iload), 32'h0);
        chk("rst_iaddr", 32'(bus.rom_iaddr), 32'h0);
        chk("rst_idata", 32'(bus.rom_idata), 32'h0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("rst_rom_ready", 32'(rom_ready), 32'h0);
        chk("rst_load_err", 32'(load_err), 32'h0);
        chk("rst_byte_count", 32'(byte_count), 32'h0);
        mon_en = 1'b1;
        tick();
        reset = 1'b0;

        // First load: four back-to-back bytes into region 0.
        bus.ioctl_download = 1'b1;
        tick();
        send(25'h0000000, 8'hAA, 4'b0001, 16'h0000);
        send(25'h0000001, 8'hBB, 4'b0001, 16'h0001);
        send(25'h0000002, 8'hCC, 4'b0001, 16'h0002);
        send(25'h0000003, 8'hDD, 4'b0001, 16'h0003);
        tick();
        @(negedge clk);
        chk("load_byte_count4", 32'(byte_count), 32'd4);
        chk("load_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("load_rom_ready", 32'(rom_ready), 32'h0);
        chk("load_err_clear", 32'(load_err), 32'h0);
        tick();

        send(25'h0021234, 8'h5A, 4'b0100, 16'h1234);
        send(25'h003FFFF, 8'hEE, 4'b1000, 16'hFFFF);
        tick();
        send(25'h0040000, 8'h77, 4'b0000, 16'h0000);
        tick();
        @(negedge clk);
        chk("ovf_load_err", 32'(load_err), 32'h1);
        chk("ovf_byte_count", 32'(byte_count), 32'd7);
        chk("ovf_iaddr_hold", 32'(bus.rom_iaddr), 32'hFFFF);
        chk("ovf_idata_hold", 32'(bus.rom_idata), 32'hEE);
        tick();

        // Settle: cpu_reset held for 17 edges after download drops.
        bus.ioctl_download = 1'b0;
        tick();
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            chk($sformatf("settle_hold_%0d", k), 32'(cpu_reset), 32'h1);
            tick();
        end
        @(negedge clk);
        chk("done_cpu_reset", 32'(cpu_reset), 32'h0);
        chk("done_rom_ready", 32'(rom_ready), 32'h1);
        tick();

        // Foreign index download while DONE.
        bus.ioctl_index    = 8'd1;
        bus.ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            send(25'(i), 8'(8'h30 + i), 4'b0000, 16'h0000);
        end
        bus.ioctl_download = 1'b0;
        tick();
        @(negedge clk);
        chk("foreign_rom_ready", 32'(rom_ready), 32'h1);
        chk("foreign_cpu_reset", 32'(cpu_reset), 32'h0);
        chk("foreign_byte_count", 32'(byte_count), 32'd7);
        chk("foreign_load_err", 32'(load_err), 32'h1);
        tick();

        // Reload from DONE.
        bus.ioctl_index    = 8'd0;
        bus.ioctl_download = 1'b1;
        tick();
        @(negedge clk);
        chk("reload_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("reload_rom_ready", 32'(rom_ready), 32'h0);
        chk("reload_byte_count", 32'(byte_count), 32'd0);
        chk("reload_load_err", 32'(load_err), 32'h0);
        tick();
        send(25'h0010000, 8'h11, 4'b0010, 16'h0000);
        send(25'h0010001, 8'h22, 4'b0010, 16'h0001);
        send(25'h0010002, 8'h33, 4'b0010, 16'h0002);

        // Reset mid-load, with a fourth byte coincident with reset.
        reset          = 1'b1;
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'h0010003;
        bus.ioctl_dout = 8'h44;
        tick();
        bus.ioctl_wr = 1'b0;
        @(negedge clk);
        chk("midrst_iload", 32'(bus.rom_iload), 32'h0);
        chk("midrst_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("midrst_rom_ready", 32'(rom_ready), 32'h0);
        tick();
        reset              = 1'b0;
        bus.ioctl_download = 1'b0;
        tick();
        send(25'h0010004, 8'h55, 4'b0000, 16'h0000);
        send(25'h0010005, 8'h66, 4'b0000, 16'h0000);
        tick();
        @(negedge clk);
        chk("post_rst_rom_ready", 32'(rom_ready), 32'h0);
        chk("post_rst_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("post_rst_byte_count", 32'(byte_count), 32'd0);
        tick();
        tick();
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
